uart_tx_fifo: RTL

Transmit buffer between the bus-side UART register wrapper and the UART core's transmitter. Accepts bytes from the bus side into a power-of-two FIFO and drains them one at a time into the core. Uses the core's tx_en/tx_busy handshake: tx_en is held until tx_busy rises, then the block waits for tx_busy to fall. Lets software queue several bytes without polling between each.

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_SEND
  } tx_state_t;

  localparam int ADDR_W_DEF    = 4;
  localparam int LOW_WATER_DEF = 2;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with occupancy count and sticky overflow.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic [7:0]        pop_data,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full     = count[ADDR_W];
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO draining bytes into the UART core via tx_en/tx_busy.
// Optional low-water IRQ enabled by defining TX_FIFO_IRQ_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LOW_WATER = LOW_WATER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_busy,
  output logic              idle
`ifdef TX_FIFO_IRQ_EN
  ,
  input  logic              irq_en,
  output logic              irqb
`endif
);

  tx_state_t  state;
  logic       pop;
  logic [7:0] pop_data;

  assign pop  = (state == TX_IDLE) & ~empty;
  assign idle = empty & (state == TX_IDLE);

  byte_fifo #(
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (pop),
    .pop_data (pop_data),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= TX_IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      unique case (state)
        TX_IDLE: begin
          if (!empty) begin
            tx_data <= pop_data;
            tx_en   <= 1'b1;
            state   <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (tx_busy) begin
            tx_en <= 1'b0;
            state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_busy) state <= TX_IDLE;
        end
        default: begin
          tx_en <= 1'b0;
          state <= TX_IDLE;
        end
      endcase
    end
  end

`ifdef TX_FIFO_IRQ_EN
  localparam logic [ADDR_W:0] LW = (ADDR_W+1)'(LOW_WATER);

  always_ff @(posedge clk) begin
    if (!reset) irqb <= 1'b1;
    else irqb <= ~(irq_en & (count <= LW));
  end
`endif

endmodule
